// File: rtl/digit_matcher_if.sv
// digit_matcher bus: pixel strobes and control in,
// captured frame and match results out.
interface digit_matcher_if;
  logic [24:0] model_in;
  logic        learn_en;
  logic        clear_tmpl;
  logic [24:0] frame_q;
  logic        frame_valid;
  logic [3:0]  tmpl_count;
  logic [3:0]  match_digit;
  logic [4:0]  match_dist;
  logic        result_valid;
  logic        busy;
  logic        frame_drop;

  modport master (
    output model_in,
    output learn_en,
    output clear_tmpl,
    input  frame_q,
    input  frame_valid,
    input  tmpl_count,
    input  match_digit,
    input  match_dist,
    input  result_valid,
    input  busy,
    input  frame_drop
  );

  modport slave (
    input  model_in,
    input  learn_en,
    input  clear_tmpl,
    output frame_q,
    output frame_valid,
    output tmpl_count,
    output match_digit,
    output match_dist,
    output result_valid,
    output busy,
    output frame_drop
  );
endinterface

// File: rtl/digit_matcher.sv
// digit_matcher: rebuilds 5x5 frames from serial strobes,
// learns digit templates and reports the nearest one.
module digit_matcher #(
  parameter int SLOT_CLKS   = 12,
  parameter int FRAME_SLOTS = 28,
  parameter int N_TMPL      = 10
) (
  input logic          clk,
  input logic          rst,
  digit_matcher_if.slave bus
);

  localparam int CW = $clog2(SLOT_CLKS);
  localparam int SW = $clog2(FRAME_SLOTS);
  localparam logic [CW-1:0] CLK_LAST  = CW'(SLOT_CLKS - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(FRAME_SLOTS - 1);
  localparam logic [3:0]    TMAX      = 4'(N_TMPL);
  localparam logic [4:0]    DIST_MAX  = 5'd25;
  localparam logic [3:0]    NONE      = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [CW-1:0] r_clk_cnt;
  logic [SW-1:0] r_slot_cnt;
  logic [24:0]   r_acc;
  logic [24:0]   r_frame_q;
  logic          r_frame_valid;
  logic          r_frame_drop;
  logic          r_cmp_req;

  logic [24:0]   r_tmpl [N_TMPL];
  logic [3:0]    r_tmpl_count;

  logic [3:0]    r_k;
  logic [4:0]    r_best_dist;
  logic [3:0]    r_best_slot;

  logic [3:0]    r_match_digit;
  logic [4:0]    r_match_dist;
  logic          r_result_valid;

  logic          w_slot_end;
  logic          w_frame_end;
  logic          w_busy;
  logic          w_cmp_step;
  logic          w_done_fire;
  logic [24:0]   w_frame_in;
  logic          w_learn_wr;
  logic [3:0]    w_idx;
  logic [24:0]   w_diff;
  logic [4:0]    w_dist;
  logic [3:0]    w_digit;

  assign w_slot_end  = (r_clk_cnt == CLK_LAST);
  assign w_frame_end = w_slot_end && (r_slot_cnt == SLOT_LAST);
  assign w_frame_in  = r_acc | bus.model_in;

  // A finished frame is stored only when not comparing,
  // there is room, and no clear is pending this cycle.
  assign w_learn_wr  = w_frame_end && !w_busy
                    && bus.learn_en
                    && (r_tmpl_count < TMAX)
                    && !bus.clear_tmpl;

  // Free-running slot/frame timer, phase-locked to upstream by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_cnt  <= '0;
      r_slot_cnt <= '0;
    end else if (w_slot_end) begin
      r_clk_cnt  <= '0;
      r_slot_cnt <= (r_slot_cnt == SLOT_LAST) ? '0
                  : r_slot_cnt + 1'b1;
    end else begin
      r_clk_cnt  <= r_clk_cnt + 1'b1;
    end
  end

  // OR-accumulate strobes; latch the frame on its last cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc         <= '0;
      r_frame_q     <= '0;
      r_frame_valid <= 1'b0;
      r_frame_drop  <= 1'b0;
      r_cmp_req     <= 1'b0;
    end else if (w_frame_end) begin
      r_acc         <= '0;
      r_frame_valid <= !w_busy;
      r_frame_drop  <= w_busy;
      r_cmp_req     <= !w_busy && !bus.learn_en;
      if (!w_busy) begin
        r_frame_q   <= w_frame_in;
      end
    end else begin
      r_acc         <= w_frame_in;
      r_frame_valid <= 1'b0;
      r_frame_drop  <= 1'b0;
      r_cmp_req     <= 1'b0;
    end
  end

  // Template store; clear takes priority over a learn write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmpl_count <= '0;
      for (int i = 0; i < N_TMPL; i++) begin
        r_tmpl[i] <= '0;
      end
    end else if (bus.clear_tmpl) begin
      r_tmpl_count <= '0;
    end else if (w_learn_wr) begin
      r_tmpl[r_tmpl_count] <= w_frame_in;
      r_tmpl_count         <= r_tmpl_count + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state: walk slots 0..count-1, clear aborts.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (r_cmp_req) begin
          if (r_tmpl_count == 4'd0 || bus.clear_tmpl) begin
            w_next = S_DONE;
          end else begin
            w_next = S_CMP;
          end
        end
      end
      S_CMP: begin
        if (bus.clear_tmpl) begin
          w_next = S_IDLE;
        end else if (r_k == r_tmpl_count - 4'd1) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // FSM outputs: busy through CMP/DONE, result unless aborted.
  always_comb begin
    w_busy      = 1'b0;
    w_cmp_step  = 1'b0;
    w_done_fire = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
      end
      S_CMP: begin
        w_busy     = 1'b1;
        w_cmp_step = !bus.clear_tmpl;
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_done_fire = !bus.clear_tmpl;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Hamming distance between the held frame and the current slot.
  always_comb begin
    w_idx  = (r_k < TMAX) ? r_k : 4'd0;
    w_diff = r_frame_q ^ r_tmpl[w_idx];
    w_dist = '0;
    for (int i = 0; i < 25; i++) begin
      w_dist = w_dist + {4'd0, w_diff[i]};
    end
  end

  // Best-so-far tracking; strict compare keeps the lowest slot on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k         <= '0;
      r_best_dist <= DIST_MAX;
      r_best_slot <= NONE;
    end else if (r_state == S_IDLE) begin
      r_k         <= '0;
      r_best_dist <= DIST_MAX;
      r_best_slot <= NONE;
    end else if (w_cmp_step) begin
      r_k <= r_k + 1'b1;
      if (w_dist < r_best_dist) begin
        r_best_dist <= w_dist;
        r_best_slot <= r_k;
      end
    end
  end

  // Slot k holds digit (k+1) mod 10.
  always_comb begin
    if (r_best_slot == NONE) begin
      w_digit = NONE;
    end else if (r_best_slot == 4'd9) begin
      w_digit = 4'd0;
    end else begin
      w_digit = r_best_slot + 4'd1;
    end
  end

  // Publish the match when DONE completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match_digit  <= NONE;
      r_match_dist   <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= w_done_fire;
      if (w_done_fire) begin
        r_match_digit <= w_digit;
        r_match_dist  <= r_best_dist;
      end
    end
  end

  assign bus.frame_q      = r_frame_q;
  assign bus.frame_valid  = r_frame_valid;
  assign bus.tmpl_count   = r_tmpl_count;
  assign bus.match_digit  = r_match_digit;
  assign bus.match_dist   = r_match_dist;
  assign bus.result_valid = r_result_valid;
  assign bus.busy         = w_busy;
  assign bus.frame_drop   = r_frame_drop;

endmodule

// File: tb/tb_digit_matcher.sv
// Directed bench for digit_matcher: learn, recognise,
// tie, clear-abort and mid-frame reset.
module tb_digit_matcher;

  logic clk = 1'b0;
  logic rst = 1'b1;

  digit_matcher_if bus ();

  digit_matcher dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int fv_cyc, rv_cyc, rv_cnt, bsy_cnt, drop_cnt;
  int base, rvb;
  logic [24:0] fv_q;
  logic [3:0]  rv_digit;
  logic [4:0]  rv_dist;
  logic [24:0] pat [10];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive len cycles of a frame; pixel i strobes in slot i+2.
  task automatic run_frame(input logic [24:0] p,
                           input logic learn,
                           input int clr_at,
                           input int len);
    int s;
    int c;
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      s = t / 12;
      c = t % 12;
      if (s >= 2 && s <= 26 && c < 6)
        bus.model_in = p & (25'd1 << (s - 2));
      else
        bus.model_in = 25'd0;
      bus.learn_en   = learn;
      bus.clear_tmpl = (t == clr_at);
      @(posedge clk);
      #1;
      cyc++;
      if (bus.frame_valid) begin
        fv_cyc = cyc;
        fv_q   = bus.frame_q;
      end
      if (bus.result_valid) begin
        rv_cnt++;
        rv_cyc   = cyc;
        rv_digit = bus.match_digit;
        rv_dist  = bus.match_dist;
      end
      if (bus.busy) bsy_cnt++;
      if (bus.frame_drop) drop_cnt++;
    end
  endtask

  initial begin
    pat[1] = 25'b00100_01100_00100_00100_01110;
    pat[2] = 25'b01110_00001_01110_10000_11111;
    pat[3] = 25'b11110_00001_01110_00001_11110;
    pat[4] = 25'b10010_10010_11111_00010_00010;
    pat[5] = 25'b11111_10000_11110_00001_11110;
    pat[6] = 25'b01110_10000_11110_10001_01110;
    pat[7] = 25'b11111_00001_00010_00100_01000;
    pat[8] = 25'b01110_10001_01110_10001_01110;
    pat[9] = 25'b01110_10001_01111_00001_01110;
    pat[0] = 25'b01110_10001_10001_10001_01110;
    fv_cyc = 0; rv_cyc = 0; rv_cnt = 0;
    bsy_cnt = 0; drop_cnt = 0;
    fv_q = '0; rv_digit = '0; rv_dist = '0;

    bus.model_in   = '0;
    bus.learn_en   = 1'b0;
    bus.clear_tmpl = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_frame_q", 32'(bus.frame_q), 0);
    chk("rst_frame_valid", 32'(bus.frame_valid), 0);
    chk("rst_tmpl_count", 32'(bus.tmpl_count), 0);
    chk("rst_match_digit", 32'(bus.match_digit), 32'hF);
    chk("rst_match_dist", 32'(bus.match_dist), 0);
    chk("rst_result_valid", 32'(bus.result_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_frame_drop", 32'(bus.frame_drop), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Empty frame with no templates
    run_frame(25'd0, 1'b0, -1, 336);
    chk("f0_valid_cycle", 32'(fv_cyc), 336);
    chk("f0_frame_q", 32'(fv_q), 0);
    base = fv_cyc;

    // Learn digit 1; previous result arrives meanwhile
    run_frame(pat[1], 1'b1, -1, 336);
    chk("empty_rv_cnt", 32'(rv_cnt), 1);
    chk("empty_latency", 32'(rv_cyc - base), 2);
    chk("empty_digit", 32'(rv_digit), 32'hF);
    chk("empty_dist", 32'(rv_dist), 25);
    chk("learn1_frame_q", 32'(fv_q), 32'(pat[1]));
    chk("learn1_count", 32'(bus.tmpl_count), 1);

    for (int d = 2; d <= 10; d++)
      run_frame(pat[d % 10], 1'b1, -1, 336);
    chk("learn10_count", 32'(bus.tmpl_count), 10);
    chk("learn_no_result", 32'(rv_cnt), 1);

    run_frame(pat[5], 1'b1, -1, 336);
    chk("learn11_count", 32'(bus.tmpl_count), 10);
    chk("learn11_frame_q", 32'(fv_q), 32'(pat[5]));

    // Recognise 7, then 7 with bit 0 flipped
    run_frame(pat[7], 1'b0, -1, 336);
    base = fv_cyc;
    rvb = rv_cnt;
    bsy_cnt = 0;
    run_frame(pat[7] ^ 25'd1, 1'b0, -1, 336);
    chk("rec7_rv_cnt", 32'(rv_cnt), 32'(rvb + 1));
    chk("rec7_latency", 32'(rv_cyc - base), 12);
    chk("rec7_digit", 32'(rv_digit), 7);
    chk("rec7_dist", 32'(rv_dist), 0);
    chk("rec7_busy_cycles", 32'(bsy_cnt), 11);
    base = fv_cyc;
    run_frame(25'd0, 1'b1, -1, 336);
    chk("rec7f_latency", 32'(rv_cyc - base), 12);
    chk("rec7f_digit", 32'(rv_digit), 7);
    chk("rec7f_dist", 32'(rv_dist), 1);
    chk("rec7f_count", 32'(bus.tmpl_count), 10);

    // clear_tmpl while comparing aborts the result
    run_frame(pat[3], 1'b0, -1, 336);
    rvb = rv_cnt;
    run_frame(25'd0, 1'b0, 4, 336);
    chk("clr_no_result", 32'(rv_cnt), 32'(rvb));
    chk("clr_count", 32'(bus.tmpl_count), 0);
    base = fv_cyc;

    // Learn tie templates A=0, B=0x3F; result of empty store arrives
    run_frame(25'd0, 1'b1, -1, 336);
    chk("clr_next_rv_cnt", 32'(rv_cnt), 32'(rvb + 1));
    chk("clr_next_latency", 32'(rv_cyc - base), 2);
    chk("clr_next_digit", 32'(rv_digit), 32'hF);
    chk("clr_next_dist", 32'(rv_dist), 25);
    chk("tieA_count", 32'(bus.tmpl_count), 1);
    run_frame(25'h3F, 1'b1, -1, 336);
    chk("tieB_count", 32'(bus.tmpl_count), 2);
    run_frame(25'h7, 1'b0, -1, 336);
    base = fv_cyc;
    run_frame(25'd0, 1'b1, -1, 336);
    chk("tie_latency", 32'(rv_cyc - base), 4);
    chk("tie_digit", 32'(rv_digit), 1);
    chk("tie_dist", 32'(rv_dist), 3);
    chk("no_drops", 32'(drop_cnt), 0);

    // Reset in the middle of a frame
    run_frame(pat[8], 1'b1, -1, 100);
    @(negedge clk);
    bus.model_in = '0;
    rst = 1'b1;
    #1;
    chk("mrst_frame_q", 32'(bus.frame_q), 0);
    chk("mrst_count", 32'(bus.tmpl_count), 0);
    chk("mrst_digit", 32'(bus.match_digit), 32'hF);
    chk("mrst_dist", 32'(bus.match_dist), 0);
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_rv", 32'(bus.result_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fv_q = '1;
    run_frame(25'd0, 1'b1, -1, 336);
    chk("mrst_partial_lost", 32'(fv_q), 0);
    chk("mrst_relearn", 32'(bus.tmpl_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
